saph_pixread_arb: RTL and testbench
===================================

# saph_pixread_arb

Shares one framebuffer pixel-read port between `NREQ` pixel requesters: requester 0 is the VGA scanout (`saph_vidgen_vga`), and requesters 1..NREQ-1 are secondary readers such as a blitter or a CPU. Scanout has strict priority, bounded by an anti-starvation burst limit; secondary requesters are served round-robin. Requester IDs are tracked in an in-order tag FIFO so each memory response returns to the requester that issued it. The block sits between the requesters' `saph_pixreadport` instances and the framebuffer read port.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, minimum 2. Index 0 is scanout.
- `XW`, 16: width of the x and y coordinates.
- `DEPTH`, 8: maximum outstanding memory reads. Must be a power of two.
- `MAXBURST`, 4: maximum consecutive scanout grants while any secondary requester is pending.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_trig`  in  NREQ  per-requester read request.
- `req_x`, `req_y`  in  NREQ×XW  per-requester pixel coordinates.
- `req_ready`  out  NREQ  one-hot grant; the request is accepted in this cycle.
- `req_valid`  out  NREQ  one-hot response strobe.
- `req_res`  out  32  response pixel (ARGB8888), shared by all requesters and qualified by `req_valid`.
- `mem_trig`  out  1  read issued to memory.
- `mem_x`, `mem_y`  out  XW  coordinates of the granted request.
- `mem_ready`  in  1  memory can accept a read this cycle.
- `mem_valid`  in  1  memory response strobe. Responses arrive in order, with arbitrary latency of 1 cycle or more.
- `mem_res`  in  32  memory response pixel.
- `err_orphan`  out  1  sticky flag: a response arrived while no read was outstanding.

## Operation
- **Grant condition:** `mem_ready` is high, the tag FIFO can accept an entry, and at least one `req_trig` is high.
- **Tag FIFO can accept:** the FIFO is not full, or it is full and a pop (`mem_valid`) occurs in the same cycle.
- **Priority:**
  - Requester 0 wins unless `burst_cnt == MAXBURST` and some secondary requester is pending. In that case the round-robin winner is granted instead.
  - Among secondary requesters, `rr_ptr` names the highest-priority index. The search runs `rr_ptr`, `rr_ptr+1`, …, wrapping from NREQ-1 back to 1.
- **On a grant to k:**
  - `req_ready[k]` is high, `mem_trig` is high, and `mem_x`/`mem_y` carry `req_x[k]`/`req_y[k]`.
  - k is pushed into the tag FIFO.
- **`burst_cnt` update:**
  - Increments on each grant to requester 0 while a secondary requester is pending, saturating at MAXBURST.
  - Clears on any grant to a secondary requester.
  - Clears in any cycle with no secondary requester pending.
- **`rr_ptr` update:** after a secondary grant to k, `rr_ptr` becomes k+1, wrapping to 1 after NREQ-1. It is unchanged on scanout grants.
- **Response:** on `mem_valid` with the FIFO non-empty:
  - Pop tag t.
  - Next cycle, `req_valid` = one-hot(t) and `req_res` = `mem_res`.
- **Orphan response:** `mem_valid` with the FIFO empty (and no same-cycle push) is dropped. `err_orphan` is set and stays set until reset.
- **Simultaneous push and pop:** allowed at any occupancy. The FIFO count is unchanged.
- **Dropped requests:** a requester that deasserts `req_trig` before being granted loses its request. There is no latching.

## Timing
- **Request path:** combinational, from `req_*` and `mem_ready` to `req_ready` and `mem_*`. No registered latency.
- **Response path:** `req_valid`/`req_res` are valid exactly 1 cycle after `mem_valid`.
- **Reset values:**
  - `req_valid` = 0, `req_res` = 0, `err_orphan` = 0.
  - FIFO empty, `rr_ptr` = 1, `burst_cnt` = 0.
  - While `rst_n` is low, `req_ready` = 0 and `mem_trig` = 0.
- **Reset mid-operation:** outstanding tags are discarded. The memory must be reset concurrently; otherwise late responses raise `err_orphan`.
- **Throughput:** 1 grant per cycle sustained while `mem_ready` is high and the FIFO is not full.

## Structure
- **Shared package:** `saph_pix_t` (32-bit ARGB) and the `saph_coord_t` width constant go in the shared `saph_defines` package.
- **Sub-module:** `saph_tag_fifo`, a synchronous FIFO of width clog2(NREQ) and depth DEPTH.
  - Outputs: `full`, `empty`, `count`.
  - Supports push and pop in the same cycle, and the full-plus-pop bypass described under Operation.
- **Top level:** the arbiter, pointer and burst counter live in `saph_pixread_arb`.

## Test plan
- **Scanout-only stream:** NREQ=2, req0 asserts continuously, memory has fixed latency 3 → one grant per cycle; each `req_valid[0]` is 4 cycles after its grant, with `req_res` equal to the memory's result.
- **Burst limit:** req0 and req1 both asserted continuously, MAXBURST=4 → grant pattern 0,0,0,0,1 repeating.
- **Round-robin:** NREQ=4, req1–req3 always asserted, req0 idle → grants 1,2,3,1,2,3. Responses are routed to the matching index.
- **FIFO full:** DEPTH=8, `mem_valid` held low → 8 grants, then `req_ready` stays 0. One `mem_valid` → one new grant in that same cycle.
- **Orphan response:** `mem_valid` pulsed after reset with nothing outstanding → no `req_valid`; `err_orphan` goes high and stays high until `rst_n` is pulsed.
- **Reset mid-operation:** `rst_n` pulled low with 5 reads outstanding → all outputs are at their reset values; after release, the first grant goes to the pending requester.

Source files
------------

// File: rtl/saph_pixread_arb_pkg.sv
// Shared pixel/coordinate types for the framebuffer read path, plus the
// secondary round-robin pointer step.
package saph_defines;

    localparam int SAPH_COORD_W = 16;

    typedef logic [SAPH_COORD_W-1:0] saph_coord_t;
    typedef logic [31:0]             saph_pix_t;

    // Secondary indices run 1..nreq-1; index 0 (scanout) is never a pointer value.
    function automatic int rr_next(input int k, input int nreq);
        return (k >= nreq - 1) ? 1 : k + 1;
    endfunction

endpackage

// File: rtl/saph_tag_fifo.sv
// In-order requester-ID FIFO. The popped tag is presented on dout one cycle
// after the pop, which lines it up with the registered response data.
module saph_tag_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = dout_q;

    // When full, a same-cycle pop frees the slot being written; the read
    // below sees the old entry because both sides are clocked.
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        dout_d   = pop_ok ? mem[rd_ptr_q] : dout_q;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/saph_pixread_arb.sv
// Arbitrates one framebuffer pixel-read port between scanout (index 0, burst-
// limited priority) and round-robin secondary readers; routes responses by tag.
module saph_pixread_arb
    import saph_defines::*;
#(
    parameter int NREQ     = 2,
    parameter int XW       = SAPH_COORD_W,
    parameter int DEPTH    = 8,
    parameter int MAXBURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_trig,
    input  logic [NREQ*XW-1:0]   req_x,
    input  logic [NREQ*XW-1:0]   req_y,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      req_valid,
    output logic [31:0]          req_res,
    output logic                 mem_trig,
    output logic [XW-1:0]        mem_x,
    output logic [XW-1:0]        mem_y,
    input  logic                 mem_ready,
    input  logic                 mem_valid,
    input  logic [31:0]          mem_res,
    output logic                 err_orphan
);
    localparam int TW = $clog2(NREQ);
    localparam int BW = $clog2(MAXBURST + 1);

    logic [XW-1:0]        x_arr [NREQ];
    logic [XW-1:0]        y_arr [NREQ];

    logic [TW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]        burst_q, burst_d;
    logic                 rsp_vld_q, rsp_vld_d;
    saph_pix_t            res_q, res_d;
    logic                 err_q, err_d;

    logic                 fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [TW-1:0]        tag_q;

    logic                 sec_pend, rr_hit, starve, go, pop, can_push, orphan;
    logic [TW-1:0]        rr_win, win;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign x_arr[gi] = req_x[gi*XW +: XW];
            assign y_arr[gi] = req_y[gi*XW +: XW];
        end
    endgenerate

    always_comb begin
        sec_pend = |req_trig[NREQ-1:1];
        rr_hit   = 1'b0;
        rr_win   = '0;
        for (int i = 0; i < NREQ - 1; i++) begin
            if (!rr_hit && req_trig[((int'(rr_ptr_q) - 1 + i) % (NREQ - 1)) + 1]) begin
                rr_hit = 1'b1;
                rr_win = TW'(((int'(rr_ptr_q) - 1 + i) % (NREQ - 1)) + 1);
            end
        end

        pop      = mem_valid && !fifo_empty;
        can_push = !fifo_full || pop;
        go       = rst_n && mem_ready && can_push && (|req_trig);
        starve   = sec_pend && (burst_q == BW'(MAXBURST));
        // With go high and scanout not eligible, a secondary must be pending.
        win      = (req_trig[0] && !starve) ? '0 : rr_win;
        orphan   = mem_valid && (fifo_count == '0) && !go;

        if (!sec_pend || (go && win != '0)) begin
            burst_d = '0;
        end else if (go && burst_q != BW'(MAXBURST)) begin
            burst_d = burst_q + BW'(1);
        end else begin
            burst_d = burst_q;
        end

        rr_ptr_d  = (go && win != '0) ? TW'(rr_next(int'(win), NREQ)) : rr_ptr_q;
        rsp_vld_d = pop;
        res_d     = pop ? mem_res : res_q;
        err_d     = err_q | orphan;
    end

    assign req_ready  = go ? (NREQ'(1) << win) : '0;
    assign mem_trig   = go;
    assign mem_x      = x_arr[win];
    assign mem_y      = y_arr[win];
    assign req_valid  = rsp_vld_q ? (NREQ'(1) << tag_q) : '0;
    assign req_res    = res_q;
    assign err_orphan = err_q;

    saph_tag_fifo #(
        .W     (TW),
        .DEPTH (DEPTH)
    ) u_tags (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (go),
        .din   (win),
        .pop   (pop),
        .dout  (tag_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= TW'(1);
            burst_q   <= '0;
            rsp_vld_q <= 1'b0;
            res_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            burst_q   <= burst_d;
            rsp_vld_q <= rsp_vld_d;
            res_q     <= res_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_saph_pixread_arb.sv
// Directed bench for saph_pixread_arb: a cycle table run against a fixed
// latency-3 memory model, then hand sequences for FIFO full, reset and orphans.
module tb_saph_pixread_arb;

    localparam int NREQ = 4;
    localparam int XW   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_trig;
    logic [NREQ*XW-1:0] req_x, req_y;
    logic [NREQ-1:0]   req_ready, req_valid;
    logic [31:0]       req_res;
    logic              mem_trig, mem_ready, mem_valid;
    logic [XW-1:0]     mem_x, mem_y;
    logic [31:0]       mem_res;
    logic              err_orphan;

    logic              model_en;
    logic              man_valid;
    logic [31:0]       man_res;
    logic [2:0]        pv;
    logic [31:0]       pd0, pd1, pd2;

    int                n_vec = 0;
    int                n_bad = 0;
    int                cyc;
    logic [3:0]        exp_rv [128];
    logic [31:0]       exp_rr [128];

    typedef struct {
        logic [3:0] trig;
        logic       mrdy;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl [$];

    always #5 clk = ~clk;

    saph_pixread_arb #(
        .NREQ(NREQ), .XW(XW), .DEPTH(8), .MAXBURST(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_trig(req_trig), .req_x(req_x), .req_y(req_y),
        .req_ready(req_ready), .req_valid(req_valid), .req_res(req_res),
        .mem_trig(mem_trig), .mem_x(mem_x), .mem_y(mem_y),
        .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_res(mem_res),
        .err_orphan(err_orphan)
    );

    function automatic logic [31:0] pix(input logic [15:0] x, input logic [15:0] y);
        return {x, y} ^ 32'hA5C3_0F1E;
    endfunction
    function automatic logic [15:0] cx(input int c, input int i);
        return 16'(c * 8 + i);
    endfunction
    function automatic logic [15:0] cy(input int c, input int i);
        return 16'(256 * i + c);
    endfunction

    // Memory model: fixed three-cycle read latency, in order.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv  <= {pv[1:0], mem_trig & model_en};
            pd0 <= pix(mem_x, mem_y);
            pd1 <= pd0;
            pd2 <= pd1;
        end
    end
    assign mem_valid = model_en ? pv[2] : man_valid;
    assign mem_res   = model_en ? pd2   : man_res;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h, expected %h", nm, cyc, act, expv);
        end
    endtask

    task automatic clear_exp();
        cyc = 0;
        for (int i = 0; i < 128; i++) begin
            exp_rv[i] = '0;
            exp_rr[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        man_valid = 1'b0;
        req_trig  = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n  = 1'b1;
        clear_exp();
    endtask

    task automatic step(input logic [3:0] trig, input logic mrdy, input logic mv,
                        input logic [31:0] mres, input logic [3:0] expg, input string nm);
        int k;
        @(posedge clk);
        #1;
        cyc++;
        req_trig  = trig;
        mem_ready = mrdy;
        man_valid = mv;
        man_res   = mres;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*XW +: XW] = cx(cyc, i);
            req_y[i*XW +: XW] = cy(cyc, i);
        end
        #3;
        $display("cyc %0d %s: trig=%b ready=%b valid=%b res=%h", cyc, nm, trig, req_ready, req_valid, req_res);
        chk({nm, "/ready"}, 32'(req_ready), 32'(expg));
        chk({nm, "/mem_trig"}, 32'(mem_trig), 32'(expg != 4'b0));
        if (expg != 4'b0) begin
            k = 0;
            for (int i = 0; i < NREQ; i++) if (expg[i]) k = i;
            chk({nm, "/mem_x"}, 32'(mem_x), 32'(cx(cyc, k)));
            chk({nm, "/mem_y"}, 32'(mem_y), 32'(cy(cyc, k)));
            if (model_en && cyc + 4 < 128) begin
                exp_rv[cyc + 4] = expg;
                exp_rr[cyc + 4] = pix(cx(cyc, k), cy(cyc, k));
            end
        end
        chk({nm, "/req_valid"}, 32'(req_valid), 32'(exp_rv[cyc]));
        if (exp_rv[cyc] != 4'b0) chk({nm, "/req_res"}, req_res, exp_rr[cyc]);
    endtask

    initial begin
        logic [3:0] rr_seq [6];
        rr_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 6; i++) tbl.push_back('{4'b1110, 1'b1, rr_seq[i]});
        for (int i = 0; i < 5; i++) tbl.push_back('{4'b0000, 1'b1, 4'b0000});
        for (int i = 0; i < 6; i++) tbl.push_back('{4'b0001, 1'b1, 4'b0001});
        for (int i = 0; i < 5; i++) tbl.push_back('{4'b0000, 1'b1, 4'b0000});
        for (int i = 0; i < 4; i++) tbl.push_back('{4'b0011, 1'b1, 4'b0001});
        tbl.push_back('{4'b0011, 1'b1, 4'b0010});
        for (int i = 0; i < 4; i++) tbl.push_back('{4'b0011, 1'b1, 4'b0001});
        tbl.push_back('{4'b0011, 1'b0, 4'b0000});   // stalled: burst limit still in force
        tbl.push_back('{4'b0011, 1'b1, 4'b0010});
        tbl.push_back('{4'b1010, 1'b1, 4'b1000});   // pointer at 2, 2 idle -> 3
        tbl.push_back('{4'b1010, 1'b1, 4'b0010});
        tbl.push_back('{4'b0110, 1'b1, 4'b0100});
        tbl.push_back('{4'b0010, 1'b1, 4'b0010});   // pointer at 3, wraps to 1
        tbl.push_back('{4'b1011, 1'b1, 4'b0001});
        for (int i = 0; i < 5; i++) tbl.push_back('{4'b0000, 1'b1, 4'b0000});

        req_x = '0; req_y = '0; mem_ready = 1'b1; man_valid = 1'b0; man_res = '0;
        model_en = 1'b1; cyc = 0;

        // Reset values, with every request line and mem_ready high.
        rst_n = 1'b1;
        req_trig = 4'b1111;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2;
        chk("rst/req_ready", 32'(req_ready), 32'h0);
        chk("rst/mem_trig", 32'(mem_trig), 32'h0);
        chk("rst/req_valid", 32'(req_valid), 32'h0);
        chk("rst/req_res", req_res, 32'h0);
        chk("rst/err_orphan", 32'(err_orphan), 32'h0);

        do_reset();
        foreach (tbl[i]) step(tbl[i].trig, tbl[i].mrdy, 1'b0, 32'h0, tbl[i].exp, "tbl");
        chk("tbl/err_orphan", 32'(err_orphan), 32'h0);

        // FIFO full: eight grants, stall, then a pop lets one grant through.
        model_en = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) step(4'b0100, 1'b1, 1'b0, 32'h0, 4'b0100, "fill");
        step(4'b0100, 1'b1, 1'b0, 32'h0, 4'b0000, "full");
        step(4'b0100, 1'b1, 1'b0, 32'h0, 4'b0000, "full");
        step(4'b0100, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'b0100, "full_pop");
        exp_rv[cyc + 1] = 4'b0100;
        exp_rr[cyc + 1] = 32'hDEAD_BEEF;
        step(4'b0100, 1'b1, 1'b0, 32'h0, 4'b0000, "full_rsp");
        step(4'b0100, 1'b1, 1'b0, 32'h0, 4'b0000, "full");
        chk("full/err_orphan", 32'(err_orphan), 32'h0);

        // Reset with five reads outstanding and a response in flight.
        do_reset();
        for (int i = 0; i < 6; i++) step(4'b0010, 1'b1, 1'b0, 32'h0, 4'b0010, "load");
        step(4'b0000, 1'b1, 1'b1, 32'h1234_5678, 4'b0000, "load_pop");
        exp_rv[cyc + 1] = 4'b0010;
        exp_rr[cyc + 1] = 32'h1234_5678;
        step(4'b0000, 1'b1, 1'b0, 32'h0, 4'b0000, "load_rsp");
        req_trig = 4'b0010;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst/req_valid", 32'(req_valid), 32'h0);
        chk("midrst/req_res", req_res, 32'h0);
        chk("midrst/req_ready", 32'(req_ready), 32'h0);
        chk("midrst/mem_trig", 32'(mem_trig), 32'h0);
        do_reset();
        step(4'b0010, 1'b1, 1'b0, 32'h0, 4'b0010, "post_rst");
        step(4'b0000, 1'b1, 1'b1, 32'hCAFE_0001, 4'b0000, "post_pop");
        exp_rv[cyc + 1] = 4'b0010;
        exp_rr[cyc + 1] = 32'hCAFE_0001;
        step(4'b0000, 1'b1, 1'b0, 32'h0, 4'b0000, "post_rsp");
        chk("post/err_orphan", 32'(err_orphan), 32'h0);

        // Tags from before reset are gone, so this response is an orphan.
        step(4'b0000, 1'b1, 1'b1, 32'h0BAD_0BAD, 4'b0000, "orphan");
        step(4'b0000, 1'b1, 1'b0, 32'h0, 4'b0000, "orphan_after");
        chk("orphan/err_orphan", 32'(err_orphan), 32'h1);
        chk("orphan/req_res_held", req_res, 32'hCAFE_0001);
        step(4'b0000, 1'b1, 1'b0, 32'h0, 4'b0000, "orphan_hold");
        step(4'b0001, 1'b1, 1'b0, 32'h0, 4'b0001, "orphan_hold");
        chk("orphan/sticky", 32'(err_orphan), 32'h1);
        do_reset();
        #1;
        chk("orphan/cleared", 32'(err_orphan), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
